// File: rtl/crt_recon_883_593.sv
// Sequential CRT reconstruction: lifts (x mod 883, x mod 593) back to the 19-bit x.
// Uses h = ((r2 - r1) * 883^-1 mod 593) via a 9-step modular double-and-add, then x = r1 + 883*h.
module crt_recon_883_593 (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  din_a,
  input  logic [9:0]  din_b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [18:0] dout_r,
  output logic        dout_err,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_MUL  = 3'd2,
    S_FIN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // 883^-1 mod 593 = 456, zero-extended so a 4-bit index never leaves the vector
  localparam logic [15:0] K_BITS = 16'h01C8;

  state_t state_r;
  state_t state_nxt;
  logic   in_ready_nxt;
  logic   out_valid_nxt;

  logic [9:0]  r1_r;
  logic [9:0]  r2_r;
  logic [10:0] d_r;
  logic        err_r;
  logic [10:0] acc_r;
  logic [3:0]  idx_r;

  logic [9:0]  r1f_s;
  logic [10:0] diff_s;
  logic [10:0] d_s;
  logic        err_s;
  logic        k_bit_s;
  logic [10:0] dbl_s;
  logic [10:0] dbl_m_s;
  logic [10:0] add_s;
  logic [10:0] add_m_s;
  logic [10:0] acc_nxt_s;
  logic [18:0] h_s;
  logic [18:0] result_s;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE: if (in_valid) state_nxt = S_PREP; else state_nxt = S_IDLE;
      S_PREP: state_nxt = S_MUL;
      S_MUL:  if (idx_r == 4'd0) state_nxt = S_FIN; else state_nxt = S_MUL;
      S_FIN:  state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE; else state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // handshake outputs are decoded from the upcoming state so they can be registered
  always_comb begin
    in_ready_nxt  = (state_nxt == S_IDLE);
    out_valid_nxt = (state_nxt == S_DONE);
  end

  // registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // modular arithmetic for PREP, MUL and FIN; every intermediate stays below 2*593
  always_comb begin
    if (r1_r >= 10'd593) r1f_s = r1_r - 10'd593;
    else                 r1f_s = r1_r;
    diff_s = {1'b0, r2_r} - {1'b0, r1f_s};
    if (r2_r < r1f_s) d_s = diff_s + 11'd593;
    else              d_s = diff_s;
    err_s = (r1_r >= 10'd883) | (r2_r >= 10'd593);

    k_bit_s = K_BITS[idx_r];
    dbl_s   = {acc_r[9:0], 1'b0};
    if (dbl_s >= 11'd593) dbl_m_s = dbl_s - 11'd593;
    else                  dbl_m_s = dbl_s;
    add_s = dbl_m_s + d_r;
    if (add_s >= 11'd593) add_m_s = add_s - 11'd593;
    else                  add_m_s = add_s;
    if (k_bit_s) acc_nxt_s = add_m_s;
    else         acc_nxt_s = dbl_m_s;

    // 883 = 512+256+64+32+16+2+1; the exact sum never exceeds 523618, so 19 bits lose nothing
    h_s      = {8'd0, acc_r};
    result_s = {9'd0, r1_r} + (h_s << 5'd9) + (h_s << 5'd8) + (h_s << 5'd6)
             + (h_s << 5'd5) + (h_s << 5'd4) + (h_s << 5'd1) + h_s;
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_r     <= 10'd0;
      r2_r     <= 10'd0;
      d_r      <= 11'd0;
      err_r    <= 1'b0;
      acc_r    <= 11'd0;
      idx_r    <= 4'd0;
      dout_r   <= 19'd0;
      dout_err <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            r1_r <= din_a;
            r2_r <= din_b;
          end
        end
        S_PREP: begin
          // bad inputs multiply a zero so the accumulator invariant still holds
          d_r   <= err_s ? 11'd0 : d_s;
          err_r <= err_s;
          acc_r <= 11'd0;
          idx_r <= 4'd8;
        end
        S_MUL: begin
          acc_r <= acc_nxt_s;
          idx_r <= idx_r - 4'd1;
        end
        S_FIN: begin
          dout_r   <= err_r ? 19'd0 : result_s;
          dout_err <= err_r;
        end
        default: begin
          dout_r <= dout_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crt_recon_883_593.sv
// Bench for crt_recon_883_593: directed table, multi-cycle corner sequences and a
// random sweep checked against a brute-force CRT search model.
module tb_crt_recon_883_593;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  din_a = 10'd0;
  logic [9:0]  din_b = 10'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [18:0] dout_r;
  logic        dout_err;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  crt_recon_883_593 dut (
    .clk(clk), .rst(rst), .din_a(din_a), .din_b(din_b), .in_valid(in_valid),
    .in_ready(in_ready), .dout_r(dout_r), .dout_err(dout_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0]  a;
    logic [9:0]  b;
    logic [18:0] exp_r;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: search h in 0..592 for the unique x = a + 883h with x mod 593 == b.
  function automatic logic [19:0] ref_model(input int a, input int b);
    int x;
    if (a >= 883 || b >= 593) return {1'b1, 19'd0};
    for (int h = 0; h < 593; h++) begin
      x = a + 883 * h;
      if (x % 593 == b) return {1'b0, 19'(x)};
    end
    return {1'b1, 19'd0};
  endfunction

  // Entered and left at a negedge; returns once out_valid is seen (or the bound expires).
  task automatic run_txn(input logic [9:0] a, input logic [9:0] b, input logic rdy,
                         output logic [18:0] r, output logic e, output int lat,
                         output int t_acc);
    int w;
    w = 0;
    out_ready = rdy;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_accept", in_ready, 1);
    din_a = a;
    din_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    t_acc = cyc;
    in_valid = 1'b0;
    din_a = 10'($urandom);
    din_b = 10'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    r = dout_r;
    e = dout_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] r;
    logic        e;
    int          lat;
    int          t;
    int          prev_t;
    int          seen;
    int          x;
    logic [9:0]  a;
    logic [9:0]  b;
    logic [19:0] m;
    logic [18:0] held_r;
    logic        held_e;

    vecs[0] = '{10'd0,    10'd0,    19'd0,      1'b0};
    vecs[1] = '{10'd0,    10'd290,  19'd883,    1'b0};
    vecs[2] = '{10'd117,  10'd407,  19'd1000,   1'b0};
    vecs[3] = '{10'd882,  10'd592,  19'd523618, 1'b0};
    vecs[4] = '{10'd719,  10'd112,  19'd123456, 1'b0};
    vecs[5] = '{10'd900,  10'd10,   19'd0,      1'b1};
    vecs[6] = '{10'd5,    10'd600,  19'd0,      1'b1};
    vecs[7] = '{10'd1023, 10'd1023, 19'd0,      1'b1};

    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_dout_r", dout_r, 0);
    check("reset_dout_err", dout_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].a, vecs[i].b, 1'b1, r, e, lat, t);
      check("table_latency", lat, 12);
      check("table_dout_r", r, vecs[i].exp_r);
      check("table_dout_err", e, vecs[i].exp_err);
    end

    // reset in cycle 5 of the (500, 50) transaction
    @(negedge clk);
    check("pre_rst_in_ready", in_ready, 1);
    din_a = 10'd500;
    din_b = 10'd50;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_busy_in_ready", in_ready, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_valid", out_valid, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_mid_no_out_valid", seen, 0);

    // backpressure: 20 stalled cycles with in_valid noise
    m = ref_model(3, 4);
    run_txn(10'd3, 10'd4, 1'b0, r, e, lat, t);
    check("bp_latency", lat, 12);
    check("bp_dout_r", r, m[18:0]);
    check("bp_dout_err", e, m[19]);
    held_r = r;
    held_e = e;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      din_a = 10'($urandom);
      din_b = 10'($urandom);
      @(negedge clk);
      check("bp_hold_dout_r", dout_r, held_r);
      check("bp_hold_dout_err", dout_err, held_e);
      check("bp_hold_out_valid", out_valid, 1);
      check("bp_hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen++;
    end
    check("bp_no_phantom_accept", seen, 0);

    // reset and out_ready together in DONE: reset wins and clears outputs
    run_txn(10'd117, 10'd407, 1'b0, r, e, lat, t);
    check("rst_done_dout_r_pre", r, 1000);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_done_out_valid", out_valid, 0);
    check("rst_done_in_ready", in_ready, 1);
    check("rst_done_dout_r", dout_r, 0);
    check("rst_done_dout_err", dout_err, 0);

    // random back-to-back sweep, alternating lifted values and raw residue pairs
    prev_t = 0;
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) begin
        x = int'($urandom_range(0, 523618));
        a = 10'(x % 883);
        b = 10'(x % 593);
      end else begin
        x = -1;
        a = 10'($urandom_range(0, 1023));
        b = 10'($urandom_range(0, 1023));
      end
      m = ref_model(int'(a), int'(b));
      run_txn(a, b, 1'b1, r, e, lat, t);
      check("rand_latency", lat, 12);
      check("rand_dout_r", r, m[18:0]);
      check("rand_dout_err", e, m[19]);
      if (x >= 0) check("rand_lift_x", r, x);
      if (k > 0) check("rand_init_interval", t - prev_t, 13);
      prev_t = t;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crt_recon_883_593.md
# crt_recon_883_593

Sequential Chinese-Remainder reconstruction unit. It takes a residue pair (x mod 883, x mod 593) and rebuilds the 19-bit integer x in [0, 523618], where 523619 = 883·593. It is the inverse-direction companion of the mod-883 Barrett reducer: the reducer narrows a 19-bit value to a residue, and this block lifts residues back to the 19-bit domain. It sits on the output side of the dual-modulus residue datapath and uses a valid/ready handshake on both ends.

## Interface
- Parameters: none. The moduli are fixed: P = 883, Q = 593, K = 883⁻¹ mod 593 = 456 (binary 111001000, 9 bits).
- clk  input  1  — single clock, rising-edge.
- rst  input  1  — synchronous, active-high reset.
- din_a  input  10  — residue r1 = x mod 883; canonical range 0..882.
- din_b  input  10  — residue r2 = x mod 593; canonical range 0..592.
- in_valid  input  1  — the din_a/din_b pair is valid.
- in_ready  output  1  — block can accept a pair; high only in IDLE.
- dout_r  output  19  — reconstructed x.
- dout_err  output  1  — the accepted inputs were out of range.
- out_valid  output  1  — dout_r and dout_err are valid; high only in DONE.
- out_ready  input  1  — downstream accepts the result.

## Operation
- Math: x = r1 + 883·h, where h = ((r2 − r1 mod 593)·456) mod 593. Maximum value is 882 + 883·592 = 523618, which fits in 19 bits.
- **IDLE**
  - in_ready = 1.
  - On in_valid, register din_a and din_b and go to PREP.
- **PREP** (1 cycle)
  - r1' = r1 − 593 if r1 ≥ 593, else r1.
  - d = r2 − r1', plus 593 if the difference is negative; d is in 0..592.
  - err = (r1 ≥ 883) | (r2 ≥ 593).
  - Clear acc to 0 and load bit index i = 8.
- **MUL** (exactly 9 cycles, i = 8 down to 0)
  - acc ← 2·acc, minus 593 if the result is ≥ 593.
  - If K[i] = 1: acc ← acc + d, minus 593 if the result is ≥ 593.
  - Invariant: acc < 593 after every cycle. The internal width is 11 bits, with no overflow.
  - After i = 0, go to FIN with h = acc.
- **FIN** (1 cycle)
  - Result register ← err ? 0 : r1 + 883·h.
  - 883·h is a constant multiply (shift-add is acceptable), computed at full 20-bit internal width and truncated to 19 bits.
  - Go to DONE.
- **DONE**
  - out_valid = 1; dout_r and dout_err are held stable.
  - When out_ready = 1, go to IDLE.
  - DONE never accepts a new input. in_valid is ignored outside IDLE.
- Out-of-range input:
  - Processing runs the full sequence, so latency does not depend on data.
  - Result: dout_r = 0, dout_err = 1.
- Reset:
  - Synchronous rst in any state returns to IDLE on the next edge.
  - Reset values: in_ready = 1, out_valid = 0, dout_r = 0, dout_err = 0.
  - Any in-flight operation is discarded; no out_valid pulse is produced for it.

## Timing
- Accept edge E0 (in_valid & in_ready). State sequence: PREP in cycle 1, MUL in cycles 2–10, FIN in cycle 11, DONE from cycle 12.
- Latency: out_valid rises 12 cycles after E0.
- out_valid stays high, with outputs stable, until the edge where out_ready = 1. IDLE follows on the next cycle.
- Minimum initiation interval is 13 cycles, reached when out_ready is held high.
- in_ready falls the cycle after E0 and returns the cycle after the output handshake.
- Simultaneous rst and out_ready in DONE: reset wins; state becomes IDLE and outputs are cleared.
- All outputs are registered. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Reset mid-MUL: rst asserted in cycle 5 after accepting (500, 50) -> IDLE next cycle, out_valid never asserts, in_ready = 1.
- Basic values:
  - (0, 0) -> dout_r = 0, err = 0, with out_valid exactly 12 cycles after acceptance.
  - (0, 290) -> 883.
  - (117, 407) -> 1000.
- Extremes:
  - (882, 592) -> 523618.
  - (719, 112) -> 123456.
- Out-of-range:
  - (900, 10) -> dout_r = 0, err = 1.
  - (5, 600) -> dout_r = 0, err = 1.
  - Latency is still 12 cycles in both cases.
- Backpressure: hold out_ready = 0 for 20 cycles in DONE -> outputs stable, in_ready = 0, in_valid pulses ignored. Then out_ready = 1 -> IDLE on the next cycle.
- Exhaustive sweep: random x in [0, 523618] drives (x mod 883, x mod 593) back-to-back with out_ready = 1 -> dout_r = x. Initiation interval is 13 cycles.
